seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/div_abs_neg.sv | 17 +
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared definitions for the sequential signed divider.
//   STATE_W  - width of the FSM state register
//   state_t  - FSM state encoding (IDLE=0, SHIFT=1, SUB=2, FIXUP=3)
package seq_divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    FIXUP = 2'd3
  } state_t;

endpackage

// File: rtl/div_abs_neg.sv
// div_abs_neg: combinational conditional two's-complement negate.
// Used as |x| when neg is tied to the sign bit, and as the sign fixup
// of quotient/remainder at the end of a division.
//   val [W-1:0] : input value
//   neg         : 1 = negate, 0 = pass through
//   res [W-1:0] : result
module div_abs_neg #(
  parameter int W = 9
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential signed restoring divider, one quotient bit per
// SHIFT/SUB pair, constant latency of 2N+1 cycles from i_start to o_finish.
// Truncates toward zero; remainder carries the sign of the dividend.
// Divide by zero returns quotient all ones, remainder = dividend, flag set.
//   i_clk, i_rst_n (sync, active-low)
//   i_start, i_dividend[N-1:0], i_divisor[N-1:0]   : request
//   o_quotient, o_remainder, o_div_by_zero, o_finish : registered result
// Optional: define SEQ_DIVIDER_FORMAL_EN to compile internal assertions.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero,
  output logic         o_finish
);

  localparam int W     = N + 1;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     quo;
  logic [W-1:0]     rem;
  logic [W-1:0]     dvs;
  logic             dvd_neg, dvs_neg, dvs_zero;

  logic [W-1:0]     dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [W:0]       diff;
  logic             unused_bits;

  // Operand magnitudes at N+1 bits so |-2^(N-1)| is exact.
  div_abs_neg #(.W(W)) u_dvd_abs (
    .val ({i_dividend[N-1], i_dividend}),
    .neg (i_dividend[N-1]),
    .res (dvd_abs)
  );

  div_abs_neg #(.W(W)) u_dvs_abs (
    .val ({i_divisor[N-1], i_divisor}),
    .neg (i_divisor[N-1]),
    .res (dvs_abs)
  );

  div_abs_neg #(.W(W)) u_quo_fix (
    .val ({1'b0, quo}),
    .neg (dvd_neg ^ dvs_neg),
    .res (quo_fix)
  );

  div_abs_neg #(.W(W)) u_rem_fix (
    .val (rem),
    .neg (dvd_neg),
    .res (rem_fix)
  );

  // Extra bit gives the borrow: diff[W]=1 means rem < divisor.
  assign diff = {1'b0, rem} - {1'b0, dvs};

  // Magnitudes never exceed 2^(N-1), so the top bits carry no information
  // once results are truncated back to N bits.
  assign unused_bits = ^{dvd_abs[N], quo_fix[N], rem_fix[N]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      dvd_neg       <= 1'b0;
      dvs_neg       <= 1'b0;
      dvs_zero      <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_finish      <= 1'b0;
    end else begin
      o_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            quo      <= dvd_abs[N-1:0];
            dvs      <= dvs_abs;
            rem      <= '0;
            dvd_neg  <= i_dividend[N-1];
            dvs_neg  <= i_divisor[N-1];
            dvs_zero <= (i_divisor == '0);
            cnt      <= CNT_INIT;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {rem, quo} <= {rem[W-2:0], quo, 1'b0};
          state      <= SUB;
        end
        SUB: begin
          if (!diff[W]) begin
            rem    <= diff[W-1:0];
            quo[0] <= 1'b1;
          end
          // Hold at zero on the last pass so cnt stays within 0..N-1.
          cnt   <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
          state <= (cnt == '0) ? FIXUP : SHIFT;
        end
        FIXUP: begin
          // A zero divisor drives every quotient bit to 1 before the sign
          // fixup; force all ones so a negative dividend still reports it.
          o_quotient    <= dvs_zero ? '1 : quo_fix[N-1:0];
          o_remainder   <= rem_fix[N-1:0];
          o_div_by_zero <= dvs_zero;
          o_finish      <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_FORMAL_EN
  logic chk_fixup;

  always_ff @(posedge i_clk) begin
    chk_fixup <= i_rst_n && (state == SUB) && (cnt == '0);
    if (i_rst_n) begin
      assert (state inside {IDLE, SHIFT, SUB, FIXUP});
      if (chk_fixup) assert (state == FIXUP);
      if (o_finish) assert (state == IDLE);
      assert (cnt <= CNT_INIT);
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_div_by_zero;
  logic         o_finish;

  int n_checks = 0;
  int n_errors = 0;
  int fin_cnt  = 0;

  seq_divider #(.N(N)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero),
    .o_finish      (o_finish)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Counts high cycles of o_finish (each pulse is one cycle wide).
  always @(posedge i_clk) if (o_finish) fin_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request; lat = edge index where o_finish is seen high (-1 = timeout).
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    @(negedge i_clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_finish) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int lat;
    run_div(a, b, lat);
    chk({tag, " latency"}, lat, 17);
    chk({tag, " quotient"}, o_quotient, eq);
    chk({tag, " remainder"}, o_remainder, er);
    chk({tag, " div_by_zero"}, o_div_by_zero, ez);
    @(posedge i_clk);
    #1 chk({tag, " finish drop"}, o_finish, 1'b0);
  endtask

  initial begin
    int lat;
    int f0;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset quotient", o_quotient, 8'h00);
    chk("reset remainder", o_remainder, 8'h00);
    chk("reset dbz", o_div_by_zero, 1'b0);
    chk("reset finish", o_finish, 1'b0);
    i_rst_n = 1'b1;

    check_div("7/2",     8'h07, 8'h02, 8'h03, 8'h01, 1'b0);
    check_div("-7/2",    8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
    check_div("7/-2",    8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
    check_div("-7/-2",   8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0);
    check_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    check_div("5/0",     8'h05, 8'h00, 8'hFF, 8'h05, 1'b1);
    check_div("-5/0",    8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1);
    check_div("127/-128", 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0);

    // Second i_start mid-operation must be ignored.
    f0 = fin_cnt;
    @(negedge i_clk);
    i_dividend = 8'd20;
    i_divisor  = 8'd6;
    i_start    = 1'b1;
    @(posedge i_clk);                 // edge 0
    #1 i_start = 1'b0;
    repeat (4) @(posedge i_clk);      // edges 1..4
    @(negedge i_clk);
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(posedge i_clk);                 // edge 5
    #1 i_start = 1'b0;
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_finish) begin
        lat = k;
        break;
      end
    end
    chk("midstart latency", lat, 17);
    chk("midstart quotient", o_quotient, 8'd3);
    chk("midstart remainder", o_remainder, 8'd2);
    repeat (25) @(posedge i_clk);
    #1 chk("midstart pulses", fin_cnt - f0, 1);

    // Reset for one edge while in SUB aborts the operation.
    @(negedge i_clk);
    i_dividend = 8'd50;
    i_divisor  = 8'd3;
    i_start    = 1'b1;
    @(posedge i_clk);                 // edge 0 -> SHIFT
    #1 i_start = 1'b0;
    @(posedge i_clk);                 // edge 1 -> SUB
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);                 // edge 2: reset taken in SUB
    #1 i_rst_n = 1'b1;
    f0 = fin_cnt;
    chk("rst quotient", o_quotient, 8'h00);
    chk("rst remainder", o_remainder, 8'h00);
    chk("rst dbz", o_div_by_zero, 1'b0);
    repeat (25) @(posedge i_clk);
    #1;
    chk("rst no pulse", fin_cnt - f0, 0);
    chk("rst quotient hold", o_quotient, 8'h00);
    check_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Back-to-back: i_start held through the o_finish cycle.
    @(negedge i_clk);
    i_dividend = 8'd9;
    i_divisor  = 8'd3;
    i_start    = 1'b1;
    @(posedge i_clk);                 // edge 0
    #1 i_start = 1'b0;
    repeat (16) @(posedge i_clk);     // edges 1..16
    @(negedge i_clk);
    i_dividend = 8'd10;
    i_divisor  = 8'd4;
    i_start    = 1'b1;
    @(posedge i_clk);                 // edge 17: FIXUP, start ignored
    #1;
    chk("b2b first finish", o_finish, 1'b1);
    chk("b2b first quotient", o_quotient, 8'd3);
    chk("b2b first remainder", o_remainder, 8'd0);
    @(posedge i_clk);                 // edge 18: start accepted
    #1 i_start = 1'b0;
    chk("b2b finish drop", o_finish, 1'b0);
    chk("b2b quotient hold", o_quotient, 8'd3);
    lat = -1;
    for (int k = 19; k <= 60; k++) begin
      @(posedge i_clk);
      #1;
      if (o_finish) begin
        lat = k;
        break;
      end
    end
    chk("b2b second edge", lat, 35);
    chk("b2b second quotient", o_quotient, 8'd2);
    chk("b2b second remainder", o_remainder, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
